// File: rtl/moore_multi_seq_det.sv
// rtl/moore_multi_seq_det.sv - Moore detector for NUM_PAT programmable serial patterns.
// Optional saturating match-event counter enabled by defining MOORE_SEQ_MATCH_CNT_EN.
module moore_multi_seq_det #(
  parameter int                           PAT_LEN     = 3,
  parameter int                           NUM_PAT     = 2,
  parameter logic [PAT_LEN*NUM_PAT-1:0]   PATTERNS    = 6'b110_101,
  parameter bit                           OVERLAP     = 1'b1,
  parameter int                           MATCH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Data_in,
  input  logic                   Data_valid,
  output logic                   Data_out,
  output logic [NUM_PAT-1:0]     match_vec,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);

  // Only the PAT_LEN-1 youngest bits are needed; the incoming bit completes the window.
  logic [PAT_LEN-2:0]             hist_q, hist_d;
  logic [NUM_PAT-1:0][FILL_W-1:0] fill_q, fill_d;
  logic [NUM_PAT-1:0]             match_vec_q, match_vec_d;
  logic [PAT_LEN-1:0]             window;
  logic [NUM_PAT-1:0]             hit_vec;

  assign window = {hist_q, Data_in};

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      hit_vec[i] = (window == PATTERNS[i*PAT_LEN +: PAT_LEN]) && (fill_q[i] >= FILL_ARM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= '0;
      fill_q      <= '0;
      match_vec_q <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_vec_q <= match_vec_d;
    end
  end

  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_vec_d = match_vec_q;
    if (Data_valid) begin
      hist_d      = window[PAT_LEN-2:0];
      match_vec_d = hit_vec;
      for (int i = 0; i < NUM_PAT; i++) begin
        if (hit_vec[i] && !OVERLAP) begin
          fill_d[i] = '0;
        end else if (fill_q[i] != FILL_MAX) begin
          fill_d[i] = fill_q[i] + FILL_W'(1);
        end
      end
    end
  end

  always_comb begin
    match_vec = match_vec_q;
    Data_out  = |match_vec_q;
  end

`ifdef MOORE_SEQ_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One increment per matching bit, regardless of how many patterns hit on it.
  always_comb begin
    cnt_d = cnt_q;
    if (Data_valid && (|hit_vec) && (cnt_q != {MATCH_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + MATCH_CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_multi_seq_det.sv
// tb/tb_moore_multi_seq_det.sv - random and directed check of moore_multi_seq_det, overlapping and non-overlapping.
module tb_moore_multi_seq_det;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Data_in = 1'b0;
  logic          Data_valid = 1'b0;
  logic          out_ov, out_no;
  logic [1:0]    vec_ov, vec_no;
  logic [CW-1:0] cnt_ov, cnt_no;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  moore_multi_seq_det #(.PAT_LEN(3), .NUM_PAT(2), .PATTERNS(6'b110_101), .OVERLAP(1'b1), .MATCH_CNT_W(CW)) dut_ov (
    .clk(clk), .rst(rst), .Data_in(Data_in), .Data_valid(Data_valid),
    .Data_out(out_ov), .match_vec(vec_ov), .match_cnt(cnt_ov));

  moore_multi_seq_det #(.PAT_LEN(3), .NUM_PAT(2), .PATTERNS(6'b110_101), .OVERLAP(1'b0), .MATCH_CNT_W(CW)) dut_no (
    .clk(clk), .rst(rst), .Data_in(Data_in), .Data_valid(Data_valid),
    .Data_out(out_no), .match_vec(vec_no), .match_cnt(cnt_no));

  // Reference: last three accepted bits as a number, bits seen since reset / since last match.
  int   pat[2] = '{5, 6};
  int   bits_q[$];
  int   total;
  int   since_no[2];
  logic [1:0] exp_vec_ov, exp_vec_no;
  int   exp_cnt_ov, exp_cnt_no;
  bit   armed = 1'b0;

  always @(posedge clk) begin
    int win;
    if (rst) begin
      bits_q.delete();
      total = 0;
      since_no[0] = 0;
      since_no[1] = 0;
      exp_vec_ov = 2'b00;
      exp_vec_no = 2'b00;
      exp_cnt_ov = 0;
      exp_cnt_no = 0;
      armed = 1'b1;
    end else if (Data_valid && armed) begin
      bits_q.push_back(int'(Data_in));
      if (bits_q.size() > 3) void'(bits_q.pop_front());
      if (total < 1000) total++;
      win = (bits_q.size() == 3) ? bits_q[0] * 4 + bits_q[1] * 2 + bits_q[2] : -1;
      for (int i = 0; i < 2; i++) begin
        if (since_no[i] < 1000) since_no[i]++;
        exp_vec_ov[i] = (total >= 3) && (win == pat[i]);
        exp_vec_no[i] = (since_no[i] >= 3) && (win == pat[i]);
        if (exp_vec_no[i]) since_no[i] = 0;
      end
      if (exp_vec_ov != 0 && exp_cnt_ov < (1 << CW) - 1) exp_cnt_ov++;
      if (exp_vec_no != 0 && exp_cnt_no < (1 << CW) - 1) exp_cnt_no++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_model(input int c);
`ifdef MOORE_SEQ_MATCH_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      check("vec_ov", 32'(vec_ov), 32'(exp_vec_ov));
      check("out_ov", 32'(out_ov), 32'(|exp_vec_ov));
      check("cnt_ov", 32'(cnt_ov), 32'(cnt_model(exp_cnt_ov)));
      check("vec_no", 32'(vec_no), 32'(exp_vec_no));
      check("out_no", 32'(out_no), 32'(|exp_vec_no));
      check("cnt_no", 32'(cnt_no), 32'(cnt_model(exp_cnt_no)));
    end
  end

  task automatic do_rst();
    rst = 1'b1;
    Data_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    Data_in = b;
    Data_valid = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    Data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic pin(input string name, input logic [1:0] want_ov, input logic [1:0] want_no);
    check({name, "_model_ov"}, 32'(exp_vec_ov), 32'(want_ov));
    check({name, "_model_no"}, 32'(exp_vec_no), 32'(want_no));
    check({name, "_dut_ov"}, 32'(vec_ov), 32'(want_ov));
    check({name, "_dut_no"}, 32'(vec_no), 32'(want_no));
  endtask

  initial begin
    @(posedge clk); #2;
    do_rst();
    pin("reset", 2'b00, 2'b00);

    // 1010101: overlapping hits at bits 3,5,7; non-overlapping at 3 and 7
    send(1); pin("s1_b1", 2'b00, 2'b00);
    send(0); pin("s1_b2", 2'b00, 2'b00);
    send(1); pin("s1_b3", 2'b01, 2'b01);
    send(0); pin("s1_b4", 2'b00, 2'b00);
    send(1); pin("s1_b5", 2'b01, 2'b00);
    send(0); pin("s1_b6", 2'b00, 2'b00);
    send(1); pin("s1_b7", 2'b01, 2'b01);

    do_rst();
    send(1); send(1);
    send(0); pin("s4_b3", 2'b10, 2'b10);
    send(1); pin("s4_b4", 2'b01, 2'b01);
    for (int k = 0; k < 5; k++) begin
      idle(1); pin("hold", 2'b01, 2'b01);
    end
    send(1); send(0);
    do_rst();
    send(1); pin("rst_mid", 2'b00, 2'b00);
    idle(1);

`ifdef MOORE_SEQ_MATCH_CNT_EN
    do_rst();
    send(1); send(0);
    send(1); check("cnt_1", 32'(cnt_ov), 32'd1);
    send(0); send(1); check("cnt_2", 32'(cnt_ov), 32'd2);
    send(0); send(1); check("cnt_3", 32'(cnt_ov), 32'd3);
    send(0); send(1); check("cnt_sat", 32'(cnt_ov), 32'd3);
    do_rst();
    check("cnt_rst", 32'(cnt_ov), 32'd0);
`else
    check("cnt_off_ov", 32'(cnt_ov), 32'd0);
    check("cnt_off_no", 32'(cnt_no), 32'd0);
`endif

    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      Data_valid = ($urandom_range(0, 3) != 0);
      Data_in    = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    rst = 1'b0;
    Data_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
